// File: rtl/counter_pkg.sv
// Shared definitions for the triangle-sweep counter slice: FSM encoding and default widths.
package counter_pkg;

    localparam int unsigned DEF_BITS = 4;
    localparam int unsigned DEF_SW   = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN_UP   = 2'd1,
        ST_RUN_DOWN = 2'd2
    } sweep_state_t;

endpackage

// File: rtl/updown_counter_ld.sv
// Loadable up/down counter; a load takes priority over a count step.
module updown_counter_ld
    import counter_pkg::*;
#(
    parameter int unsigned BITS = DEF_BITS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [BITS-1:0] load_val,
    input  logic            en,
    input  logic            up,
    output logic [BITS-1:0] q
);

    logic [BITS-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= load_val;
        end else if (en) begin
            r_q <= up ? r_q + BITS'(1) : r_q - BITS'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sequences an up/down counter through lo->hi->lo triangle sweeps, one-shot or continuous,
// with pause, abort and a completed-sweep count.
module counter_sweep_ctrl
    import counter_pkg::*;
#(
    parameter int unsigned BITS = DEF_BITS,
    parameter int unsigned SW   = DEF_SW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stop,
    input  logic            pause,
    input  logic            cont,
    input  logic [BITS-1:0] lo,
    input  logic [BITS-1:0] hi,
    output logic [BITS-1:0] q,
    output logic            up,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [SW-1:0]   sweeps
);

    sweep_state_t    r_state;
    logic [BITS-1:0] r_lo;
    logic [BITS-1:0] r_hi;
    logic            r_cont;
    logic            r_up;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic [SW-1:0]   r_sweeps;

    logic [BITS-1:0] w_q;
    logic [BITS-1:0] w_q_inc;
    logic [BITS-1:0] w_q_dec;
    logic            w_lo_ok;
    logic            w_load;
    logic            w_en;
    logic            w_dir_up;

    // Limits never let q leave [lo, hi], so these never wrap while a step is taken.
    assign w_q_inc = w_q + BITS'(1);
    assign w_q_dec = w_q - BITS'(1);
    assign w_lo_ok = lo < hi;

    // Counter controls for the step taken at the coming edge.
    always_comb begin
        w_load   = 1'b0;
        w_en     = 1'b0;
        w_dir_up = 1'b0;
        if (!stop) begin
            case (r_state)
                ST_IDLE:     w_load = start && w_lo_ok;
                ST_RUN_UP:   begin w_en = !pause; w_dir_up = 1'b1; end
                ST_RUN_DOWN: w_en = !pause;
                default:     w_en = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_lo     <= '0;
            r_hi     <= '0;
            r_cont   <= 1'b0;
            r_up     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_sweeps <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (stop) begin
                r_state <= ST_IDLE;
                r_up    <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start && w_lo_ok) begin
                            r_lo     <= lo;
                            r_hi     <= hi;
                            r_cont   <= cont;
                            r_sweeps <= '0;
                            r_state  <= ST_RUN_UP;
                            r_up     <= 1'b1;
                            r_busy   <= 1'b1;
                        end else if (start) begin
                            r_err <= 1'b1;
                        end
                    end
                    ST_RUN_UP: begin
                        if (!pause && (w_q_inc == r_hi)) begin
                            r_state <= ST_RUN_DOWN;
                            r_up    <= 1'b0;
                        end
                    end
                    ST_RUN_DOWN: begin
                        if (!pause && (w_q_dec == r_lo)) begin
                            r_sweeps <= r_sweeps + SW'(1);
                            if (r_cont) begin
                                r_state <= ST_RUN_UP;
                                r_up    <= 1'b1;
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    updown_counter_ld #(.BITS(BITS)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .load_val (lo),
        .en       (w_en),
        .up       (w_dir_up),
        .q        (w_q)
    );

    assign q      = w_q;
    assign up     = r_up;
    assign busy   = r_busy;
    assign done   = r_done;
    assign err    = r_err;
    assign sweeps = r_sweeps;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Scoreboard bench for counter_sweep_ctrl: expected outputs queued per edge, popped after it.
module tb_counter_sweep_ctrl;

    typedef struct packed {
        logic [3:0] q;
        logic       up;
        logic       busy;
        logic       done;
        logic       err;
        logic [7:0] sweeps;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic       pause;
    logic       cont;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [3:0] q;
    logic       up;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] sweeps;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    counter_sweep_ctrl #(.BITS(4), .SW(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .stop   (stop),
        .pause  (pause),
        .cont   (cont),
        .lo     (lo),
        .hi     (hi),
        .q      (q),
        .up     (up),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .sweeps (sweeps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [3:0] eq, input logic eup, input logic ebusy,
                                input logic edone, input logic eerr, input logic [7:0] esw);
        exp_t e;
        e.q = eq; e.up = eup; e.busy = ebusy; e.done = edone; e.err = eerr; e.sweeps = esw;
        return e;
    endfunction

    function automatic exp_t sample();
        return mk(q, up, busy, done, err, sweeps);
    endfunction

    function automatic string fmt(input exp_t e);
        return $sformatf("q=%0d up=%b busy=%b done=%b err=%b sweeps=%0d",
                         e.q, e.up, e.busy, e.done, e.err, e.sweeps);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e, o;
        reset = 1'b1;
        sb.push_back(mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
        tick();
        reset = 1'b0;
        sb.push_back(mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
        tick();
        for (int i = 0; i < 2; i++) begin
            e = sb.pop_front();
            o = sample();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset[%0d] got %s want %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_oneshot();
        logic [3:0] qt[8] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd4, 4'd3, 4'd2, 4'd2};
        exp_t e, o;
        lo = 4'd2; hi = 4'd5; cont = 1'b0;
        for (int i = 0; i < 8; i++) begin
            start = (i == 0);
            sb.push_back(mk(qt[i], i < 3, i < 6, i == 6, 1'b0, (i >= 6) ? 8'd1 : 8'd0));
            tick();
            e = sb.pop_front();
            o = sample();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL oneshot[%0d] got %s want %s", i, fmt(o), fmt(e));
            end
        end
        start = 1'b0;
    endtask

    task automatic test_continuous();
        exp_t e, o;
        lo = 4'd0; hi = 4'd15; cont = 1'b1;
        start = 1'b1;
        sb.push_back(mk(4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0));
        tick();
        start = 1'b0;
        e = sb.pop_front();
        o = sample();
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL cont_start got %s want %s", fmt(o), fmt(e));
        end
        for (int s = 0; s < 3; s++) begin
            for (int v = 1; v <= 30; v++) begin
                if (v <= 15)
                    sb.push_back(mk(4'(v), v != 15, 1'b1, 1'b0, 1'b0, 8'(s)));
                else
                    sb.push_back(mk(4'(30 - v), v == 30, 1'b1, 1'b0, 1'b0,
                                    (v == 30) ? 8'(s + 1) : 8'(s)));
                tick();
                e = sb.pop_front();
                o = sample();
                n_checks++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL cont[s%0d v%0d] got %s want %s", s, v, fmt(o), fmt(e));
                end
            end
        end
        // Abort at the bottom while heading up: q holds 0, count kept.
        stop = 1'b1;
        sb.push_back(mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3));
        tick();
        stop = 1'b0;
        e = sb.pop_front();
        o = sample();
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL cont_stop got %s want %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_err();
        logic [3:0] lt[4] = '{4'd7, 4'd7, 4'd9, 4'd9};
        logic [3:0] ht[4] = '{4'd7, 4'd7, 4'd3, 4'd3};
        exp_t e, o;
        cont = 1'b0;
        for (int i = 0; i < 4; i++) begin
            lo = lt[i]; hi = ht[i];
            start = (i % 2 == 0);
            sb.push_back(mk(4'd0, 1'b0, 1'b0, 1'b0, i % 2 == 0, 8'd3));
            tick();
            e = sb.pop_front();
            o = sample();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL err[%0d] got %s want %s", i, fmt(o), fmt(e));
            end
        end
        start = 1'b0;
    endtask

    task automatic test_pause();
        logic [3:0] qt[11] = '{4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd4, 4'd5, 4'd4, 4'd3, 4'd2, 4'd2};
        exp_t e, o;
        lo = 4'd2; hi = 4'd5; cont = 1'b0;
        for (int i = 0; i < 11; i++) begin
            start = (i == 0);
            pause = (i >= 3) && (i <= 5);
            sb.push_back(mk(qt[i], i < 6, i < 9, i == 9, 1'b0, (i >= 9) ? 8'd1 : 8'd0));
            tick();
            e = sb.pop_front();
            o = sample();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL pause[%0d] got %s want %s", i, fmt(o), fmt(e));
            end
        end
        start = 1'b0;
        pause = 1'b0;
    endtask

    task automatic test_stop_down();
        logic [3:0] qt[8] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd4, 4'd3, 4'd3, 4'd3};
        exp_t e, o;
        lo = 4'd2; hi = 4'd5; cont = 1'b0;
        for (int i = 0; i < 8; i++) begin
            start = (i == 0);
            stop  = (i == 6);
            sb.push_back(mk(qt[i], i < 3, i < 6, 1'b0, 1'b0, 8'd0));
            tick();
            e = sb.pop_front();
            o = sample();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL stop[%0d] got %s want %s", i, fmt(o), fmt(e));
            end
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] qt[8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd3, 4'd2, 4'd1, 4'd1};
        exp_t e, o;
        lo = 4'd1; hi = 4'd4; cont = 1'b0;
        for (int i = 0; i < 8; i++) begin
            start = (i <= 5);
            if (i == 1) begin
                lo = 4'd0; hi = 4'd9; cont = 1'b1;
            end
            sb.push_back(mk(qt[i], i < 3, i < 6, i == 6, 1'b0, (i >= 6) ? 8'd1 : 8'd0));
            tick();
            e = sb.pop_front();
            o = sample();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL b2b[%0d] got %s want %s", i, fmt(o), fmt(e));
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [3:0] qt[7] = '{4'd2, 4'd3, 4'd2, 4'd3, 4'd2, 4'd0, 4'd0};
        logic [7:0] st[7] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd0, 8'd0};
        exp_t e, o;
        lo = 4'd2; hi = 4'd3; cont = 1'b1;
        for (int i = 0; i < 7; i++) begin
            start = (i == 0);
            reset = (i == 5);
            sb.push_back(mk(qt[i], (i < 5) && (i % 2 == 0), i < 5, 1'b0, 1'b0, st[i]));
            tick();
            e = sb.pop_front();
            o = sample();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_mid[%0d] got %s want %s", i, fmt(o), fmt(e));
            end
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        pause = 1'b0;
        cont  = 1'b0;
        lo    = 4'd0;
        hi    = 4'd0;
        test_reset();
        test_oneshot();
        test_continuous();
        test_err();
        test_pause();
        test_stop_down();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
